rns_mod_add_pipe: RTL
=====================

Name: rns_mod_add_pipe

Overview:
Parametrised, two-stage pipelined modular adder/subtractor for one residue channel of the RNS datapath. It computes (a ± b) mod MOD on WIDTH-bit residues using a generalised carry-lookahead adder. It sits between the forward converter and the RNS multiplier/reverse-converter chain, with valid/ready handshakes on both sides and full back-pressure support.

Parameters:
WIDTH, 4, residue bit width; legal range 2..32
MOD, 15, channel modulus; must satisfy 2 <= MOD <= 2**WIDTH (elaboration-time check, fatal on violation)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat present
in_ready  out  1  block accepts beat this cycle
op  in  1  0 = add, 1 = subtract (a - b)
a  in  WIDTH  residue operand, expected < MOD
b  in  WIDTH  residue operand, expected < MOD
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
result  out  WIDTH  (a op b) mod MOD
err  out  1  operand out of range; qualified by out_valid

Behaviour:
- Reset, asynchronous: s1_valid = s2_valid = 0; out_valid = 0, result = 0, err = 0; in_ready = 1 immediately after reset deasserts. All in-flight beats are discarded. Reset mid-operation loses data by design.
- Accept condition: in_valid && in_ready. Output transfer condition: out_valid && out_ready.
- Stage 2 register, which drives the outputs: loads when !s2_valid || out_ready. Stage 1 register loads when !s1_valid || stage2_load.
- in_ready = !s1_valid || stage2_load. in_ready is combinational from out_ready, with no combinational path from in_valid.
- Latency: 2 cycles from accept to out_valid when not stalled. Throughput: 1 beat per cycle.
- Stall: while out_valid && !out_ready, result, err and out_valid stay stable. Stage 1 holds once it is full.
- Stage 1 arithmetic:
  - range = (a >= MOD) || (b >= MOD).
  - bb = op ? (MOD - b) : b, computed at WIDTH+1 bits. For op=1 with b=0, bb = MOD.
  - t = a + bb via CLA, at WIDTH+1 bits with carry-out kept as the MSB.
  - Register t, range and valid.
- Stage 2 arithmetic:
  - d = t - MOD at WIDTH+2 bits.
  - result = (t >= MOD) ? d[WIDTH-1:0] : t[WIDTH-1:0].
  - If range is set, result = 0 and err = 1; otherwise err = 0.
- Given in-range inputs, t < 2*MOD always holds, so a single conditional subtract is sufficient.
- Boundary cases:
  - MOD = 2**WIDTH: the wrap comes from the carry-out only.
  - a = b = MOD-1 with add gives 2*MOD-2, so result = MOD-2.
  - Subtract with a = b gives 0.
- Simultaneous accept and output transfer in the same cycle is legal and sustains full rate.
- No X propagation: t and range register only on load, and their values are don't-care while the corresponding valid is low.

Decomposition:
- Shared package rns_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1
  - Default channel moduli constants (e.g. RNS_M0 = 15, RNS_M1 = 16, RNS_M2 = 17)
  - A function clog2 for width derivation
- Sub-module cla_add_n (parameter N):
  - Purely combinational N-bit carry-lookahead adder with cin, a, b, sum and cout ports.
  - Built from 4-bit lookahead groups (generate/propagate per bit, group G/P) chained by a second-level lookahead.
  - Instantiated once for stage 1's add. Stage 2's subtract may reuse a second instance with cin = 1 and an inverted operand.

Test Plan:
- Reset, WIDTH=4, MOD=15: assert rst mid-stream with 2 beats in flight -> out_valid=0, result=0, err=0 at once. After release, in_ready=1 and no stale beat emerges.
- Add wrap, MOD=15: a=9, b=8, op=0, out_ready=1 -> after 2 cycles out_valid=1, result=2, err=0. Also a=14, b=14 -> result=13.
- Subtract, MOD=15: a=3, b=7, op=1 -> result=11. a=5, b=0 -> result=5. a=6, b=6 -> result=0.
- Back-pressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 3 cycles -> in_ready drops after 2 beats are held and result=2 stays stable. On release, results 2, 4, 6, 8 appear in order with no loss or duplication.
- Range error, MOD=15: a=15, b=1 -> err=1, result=0. The next beat a=1, b=1 -> err=0, result=2.
- Full-power-of-two modulus, WIDTH=4, MOD=16: a=15, b=3, op=0 -> result=2. a=0, b=1, op=1 -> result=15. Sustained back-to-back stream at 1 beat per cycle with random out_ready -> matches the reference model.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared RNS datapath definitions: opcode encodings, default channel moduli and a
// width helper used for parameter validation.
package rns_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned RNS_M0 = 15;
  localparam int unsigned RNS_M1 = 16;
  localparam int unsigned RNS_M2 = 17;

  // Smallest r such that 2**r >= value.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned pow;
    int unsigned     r;
    pow = 1;
    r   = 0;
    for (int i = 0; i < 64; i++) begin
      if (pow < value) begin
        pow = pow << 1;
        r   = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_add_n.sv
// Combinational N-bit carry-lookahead adder: 4-bit lookahead groups whose group
// generate/propagate terms feed a second-level lookahead for the group carries.
module cla_add_n #(
  parameter int unsigned N = 8
) (
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NI = int'(N);
  localparam int NG = (NI + 3) / 4;

  logic [N-1:0]  w_g;
  logic [N-1:0]  w_p;
  logic [N-1:0]  w_c;
  logic [NG-1:0] w_grp_g;
  logic [NG-1:0] w_grp_p;
  logic [NG:0]   w_grp_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_grp_g = '0;
    w_grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      w_grp_p[k] = 1'b1;
      for (int i = 4 * k; (i < 4 * k + 4) && (i < NI); i++) begin
        w_grp_g[k] = w_g[i] | (w_p[i] & w_grp_g[k]);
        w_grp_p[k] = w_grp_p[k] & w_p[i];
      end
    end
  end

  // Each group carry is a flat sum of products over all lower groups and cin.
  always_comb begin
    logic acc;
    logic prop;
    acc     = 1'b0;
    prop    = 1'b0;
    w_grp_c = '0;
    w_grp_c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      acc  = w_grp_g[k];
      prop = w_grp_p[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prop & w_grp_g[j]);
        prop = prop & w_grp_p[j];
      end
      w_grp_c[k+1] = acc | (prop & cin);
    end
  end

  always_comb begin
    logic acc;
    acc = 1'b0;
    w_c = '0;
    for (int i = 0; i < NI; i++) begin
      acc = w_grp_c[i/4];
      for (int j = (i / 4) * 4; j < i; j++) begin
        acc = w_g[j] | (w_p[j] & acc);
      end
      w_c[i] = acc;
    end
  end

  assign sum  = w_p ^ w_c;
  assign cout = w_grp_c[NG];

endmodule

// File: rtl/rns_mod_add_pipe.sv
// Two-stage pipelined (a +/- b) mod MOD for one residue channel, valid/ready on both
// sides. Stage 1 forms t = a + b' with a CLA; stage 2 applies one conditional subtract.
module rns_mod_add_pipe
  import rns_pkg::*;
#(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  if (WIDTH < 2 || WIDTH > 32 || MOD < 2 || clog2(MOD) > WIDTH) begin : g_param_check
    $fatal(1, "rns_mod_add_pipe: illegal WIDTH/MOD combination");
  end

  localparam logic [WIDTH:0] MOD_W1 = (WIDTH + 1)'(MOD);

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_accept;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_b_ext;
  logic [WIDTH:0]   w_bb;
  logic [WIDTH-1:0] w_sum1;
  logic             w_cout1;
  logic [WIDTH:0]   w_t;
  logic             w_range;
  logic [WIDTH:0]   r_t;
  logic             r_range;
  logic [WIDTH:0]   w_d;
  logic             w_d_cout;
  logic             w_wrap;
  logic [WIDTH-1:0] w_mod_res;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && w_s1_load;
  assign in_ready  = w_s1_load;

  // Stage 1: range check and operand conditioning.
  assign w_a_ext = {1'b0, a};
  assign w_b_ext = {1'b0, b};
  assign w_range = (w_a_ext >= MOD_W1) || (w_b_ext >= MOD_W1);
  assign w_bb    = (op == OP_SUB) ? (MOD_W1 - w_b_ext) : w_b_ext;

  cla_add_n #(
    .N (WIDTH)
  ) u_add (
    .cin  (1'b0),
    .a    (a),
    .b    (w_bb[WIDTH-1:0]),
    .sum  (w_sum1),
    .cout (w_cout1)
  );

  // In range, bb[WIDTH] is set only when bb == MOD == 2**WIDTH, whose low bits are zero.
  assign w_t = {w_cout1 | w_bb[WIDTH], w_sum1};

  // Stage 2: d = t - MOD as t + ~MOD + 1; carry-out means t >= MOD.
  cla_add_n #(
    .N (WIDTH + 1)
  ) u_sub (
    .cin  (1'b1),
    .a    (r_t),
    .b    (~MOD_W1),
    .sum  (w_d),
    .cout (w_d_cout)
  );

  // In range t < 2*MOD, so d < MOD and d[WIDTH] is clear whenever the wrap applies.
  assign w_wrap    = w_d_cout && !w_d[WIDTH];
  assign w_mod_res = w_wrap ? w_d[WIDTH-1:0] : r_t[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_err    <= r_range;
          r_result <= r_range ? '0 : w_mod_res;
        end
      end
    end
  end

  // Datapath payload only moves with an accepted beat; it is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_t     <= w_t;
      r_range <= w_range;
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign err       = r_err;

endmodule
